// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, source IDs
// and the default transmitter acknowledge timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  localparam logic SRC_ECHO = 1'b0;
  localparam logic SRC_MSG  = 1'b1;

  localparam int TO_CYCLES_DEFAULT = 2048;

endpackage

// File: rtl/uart_rr_pick2.sv
// Two-way round-robin winner selection: a lone valid always wins, a tie goes
// to the requester named by ptr.
module uart_rr_pick2
  import uart_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  output logic win,
  output logic any
);

  always_comb begin
    any = valid0 | valid1;
    if (valid0 && valid1) begin
      win = ptr;
    end else if (valid1) begin
      win = SRC_MSG;
    end else begin
      win = SRC_ECHO;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from an RX-echo and a message source.
// Optional tx_busy acknowledge timeout is compiled in with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int   TO_CYCLES  = TO_CYCLES_DEFAULT,
  parameter logic PRIO_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       grant_src,
  output logic       arb_busy,
  output logic       err_timeout
);

  arb_state_t state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       grant_src_q, grant_src_d;
  logic       win, any, accept;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
`endif

  uart_rr_pick2 u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (rr_ptr_q),
    .win    (win),
    .any    (any)
  );

  // reset is folded in so the readies drop the instant reset asserts
  assign accept     = (state_q == ST_IDLE) && any && reset;
  assign req0_ready = accept && (win == SRC_ECHO);
  assign req1_ready = accept && (win == SRC_MSG);
  assign tx_start   = (state_q == ST_START);
  assign arb_busy   = (state_q != ST_IDLE);
  assign tx_data    = tx_data_q;
  assign grant_src  = grant_src_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    tx_data_d   = tx_data_q;
    grant_src_d = grant_src_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_START;
          rr_ptr_d    = ~win;
          tx_data_d   = win ? req1_data : req0_data;
          grant_src_d = win;
        end
      end
      ST_START:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (tx_busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
    // Counter only advances while parked in a wait state; any move clears it.
    to_cnt_d = '0;
    err_d    = err_q;
    if ((state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) && state_d == state_q) begin
      if (to_cnt_q == CNT_W'(TO_CYCLES - 1)) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= PRIO_RESET;
      tx_data_q   <= 8'h00;
      grant_src_q <= SRC_ECHO;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_data_q   <= tx_data_d;
      grant_src_q <= grant_src_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb with a transaction-level reference model
// of the arbitration rules and a behavioural UART transmitter.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       tx_start, grant_src, arb_busy, err_timeout;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;

  uart_tx_arb #(.TO_CYCLES(TO), .PRIO_RESET(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_src   (grant_src),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  // Reference model: line free / start owed / waiting for busy to rise / to fall
  bit         m_free = 1'b1, m_start_due = 1'b0, m_wait_ack = 1'b0, m_wait_done = 1'b0;
  bit         m_ptr = 1'b0, m_err = 1'b0;
  int         m_wcnt = 0;
  logic [7:0] exp_data = 8'h00;
  bit         exp_src = 1'b0;
  logic [7:0] q0[$], q1[$], sent[$];

  // Requester and transmitter behaviour knobs
  bit rand_gate = 1'b0;
  bit tx_en = 1'b1;
  int ack_max = 0, busy_min = 1, busy_max = 1;
  int x_delay = 0, x_rem = 0;

  task automatic model_reset();
    m_free = 1'b1; m_start_due = 1'b0; m_wait_ack = 1'b0; m_wait_done = 1'b0;
    m_ptr = 1'b0; m_err = 1'b0; m_wcnt = 0;
    x_delay = 0; x_rem = 0;
  endtask

  task automatic cycle();
    bit w, e0, e1, pop0, pop1, busy_nx;
    @(negedge clk);
    w = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    e0 = m_free && req0_valid && !w;
    e1 = m_free && req1_valid && w;
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("tx_start", tx_start, m_start_due);
    check("arb_busy", arb_busy, !m_free);
    check("err_timeout", err_timeout, m_err);
    if (!m_free) begin
      check("tx_data", tx_data, exp_data);
      check("grant_src", grant_src, exp_src);
    end
    if (tx_start) $display("tx_start src=%0d data=%02h", grant_src, tx_data);

    if (m_free) begin
      if (e0 || e1) begin
        m_free = 1'b0; m_start_due = 1'b1;
        exp_src = w;
        exp_data = w ? q1[0] : q0[0];
        sent.push_back(exp_data);
        m_ptr = !w;
        m_wcnt = 0;
      end
    end else if (m_start_due) begin
      m_start_due = 1'b0; m_wait_ack = 1'b1; m_wcnt = 0;
    end else if (m_wait_ack && tx_busy) begin
      m_wait_ack = 1'b0; m_wait_done = 1'b1; m_wcnt = 0;
    end else if (m_wait_done && !tx_busy) begin
      m_wait_done = 1'b0; m_free = 1'b1; m_wcnt = 0;
    end else if (TIMEOUT_ON) begin
      m_wcnt++;
      if (m_wcnt == TO) begin
        m_wait_ack = 1'b0; m_wait_done = 1'b0; m_free = 1'b1; m_err = 1'b1; m_wcnt = 0;
      end
    end

    pop0 = req0_valid && req0_ready;
    pop1 = req1_valid && req1_ready;

    if (tx_start && tx_en) begin
      x_delay = $urandom_range(ack_max, 0);
      x_rem   = $urandom_range(busy_max, busy_min);
    end
    if (x_delay > 0) begin
      x_delay--; busy_nx = 1'b0;
    end else if (x_rem > 0) begin
      x_rem--; busy_nx = 1'b1;
    end else begin
      busy_nx = 1'b0;
    end

    @(posedge clk); #1;
    tx_busy = busy_nx;
    if (pop0) begin void'(q0.pop_front()); req0_valid = 1'b0; end
    if (pop1) begin void'(q1.pop_front()); req1_valid = 1'b0; end
    if (!req0_valid && q0.size() > 0 && (!rand_gate || $urandom_range(2, 0) == 0)) req0_valid = 1'b1;
    if (!req1_valid && q1.size() > 0 && (!rand_gate || $urandom_range(2, 0) == 0)) req1_valid = 1'b1;
    req0_data = (q0.size() > 0) ? q0[0] : 8'h00;
    req1_data = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    bit done;
    while (!(q0.size() == 0 && q1.size() == 0 && m_free && !req0_valid && !req1_valid)
           && n < max_cycles) begin
      cycle();
      n++;
    end
    done = (n < max_cycles);
    check(tag, done, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    tx_busy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_arb_busy"}, arb_busy, 1'b0);
    check({tag, "_ready0"}, req0_ready, 1'b0);
    check({tag, "_ready1"}, req1_ready, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_grant_src"}, grant_src, 1'b0);
    check({tag, "_err"}, err_timeout, 1'b0);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    logic [7:0] order_exp[4];

    // Reset state, with requester 0 already offering 8'h41
    q0.push_back(8'h41);
    req0_valid = 1'b1;
    req0_data  = 8'h41;
    #3;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ack_max = 1; busy_min = 3; busy_max = 5;
    drain("single_drain", 100);
    check("single_sent", sent.size(), 1);
    if (sent.size() > 0) check("single_byte", sent[0], 8'h41);

    // Both requesters loaded, pointer freshly reset to requester 0
    do_reset();
    sent.delete();
    q0.push_back(8'h55); q0.push_back(8'h55);
    q1.push_back(8'hAA); q1.push_back(8'hAA);
    drain("rr_drain", 200);
    order_exp[0] = 8'h55; order_exp[1] = 8'hAA; order_exp[2] = 8'h55; order_exp[3] = 8'hAA;
    check("rr_count", sent.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < sent.size()) check($sformatf("rr_order%0d", i), sent[i], order_exp[i]);

    // Long frame: requester 1 keeps valid up while tx_busy is high for 20 cycles
    ack_max = 0; busy_min = 20; busy_max = 20;
    q1.push_back(8'h31); q1.push_back(8'h32); q1.push_back(8'h33);
    drain("long_drain", 300);

    // Randomized traffic with random valid gating and transmitter timing
    rand_gate = 1'b1;
    ack_max = 3; busy_min = 1; busy_max = 6;
    sent.delete();
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      if ($urandom_range(1, 0) == 1) q1.push_back(b); else q0.push_back(b);
    end
    drain("rand_drain", 3000);
    check("rand_count", sent.size(), 40);
    rand_gate = 1'b0;

    // Asynchronous reset while in WAIT_DONE abandons the byte
    ack_max = 0; busy_min = 8; busy_max = 8;
    q0.push_back(8'hC3);
    n = 0;
    while (!m_wait_done && n < 50) begin cycle(); n++; end
    check("reach_wait_done", m_wait_done, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tx_busy = 1'b0;
    model_reset();
    @(posedge clk); #1 reset = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (tx_start) n++;
    end
    check("no_retry_starts", n, 0);

    // Transmitter never acknowledges
    tx_en = 1'b0;
    q1.push_back(8'h7E);
    for (int i = 0; i < TO + 8; i++) cycle();
    check("timeout_err", err_timeout, TIMEOUT_ON);
    check("timeout_busy", arb_busy, !TIMEOUT_ON);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
